// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter: two valid/ready request ports and one result port.
// The arbiter side uses the slave modport; requesters and the result consumer use master.
interface shift_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [5:0]       req0_amt;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [5:0]       req1_amt;
    logic [1:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_op,
        input  req1_valid, req1_data, req1_amt, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport master (
        output req0_valid, req0_data, req0_amt, req0_op,
        output req1_valid, req1_data, req1_amt, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 64-bit barrel shifter between two requesters, with a registered result.
// Define SHIFT_ARB_ROTATE_EN to build ROR for op 11; otherwise op 11 returns 0 with rsp_err set.
module shift_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    shift_arbiter_if.slave bus
);
    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic             can_acc;
    logic             gnt_valid;
    logic             gnt_id;

    logic [WIDTH-1:0] sh_data;
    logic [5:0]       sh_amt;
    logic [1:0]       sh_op;
    logic [WIDTH-1:0] sh_result;
    logic             sh_err;

    logic             prio_d,      prio_q;
    logic             rsp_valid_d, rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_d,  rsp_data_q;
    logic             rsp_id_d,    rsp_id_q;
    logic             rsp_err_d,   rsp_err_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        can_acc   = !rsp_valid_q || bus.rsp_ready;
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (!rst && can_acc) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = prio_q;
            end else if (bus.req0_valid) begin
                gnt_valid = 1'b1;
            end else if (bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign bus.req0_ready = gnt_valid && !gnt_id;
    assign bus.req1_ready = gnt_valid &&  gnt_id;

    assign sh_data = gnt_id ? bus.req1_data : bus.req0_data;
    assign sh_amt  = gnt_id ? bus.req1_amt  : bus.req0_amt;
    assign sh_op   = gnt_id ? bus.req1_op   : bus.req0_op;

    always_comb begin
        sh_result = '0;
        sh_err    = 1'b0;
        case (sh_op)
            OP_SRL: sh_result = sh_data >> sh_amt;
            OP_SLL: sh_result = sh_data << sh_amt;
            OP_SRA: sh_result = $signed(sh_data) >>> sh_amt;
            OP_ROR: begin
`ifdef SHIFT_ARB_ROTATE_EN
                // A left shift by 64 yields zero, so amount 0 falls out as the operand itself.
                sh_result = (sh_data >> sh_amt) | (sh_data << (7'd64 - {1'b0, sh_amt}));
`else
                sh_err    = 1'b1;
`endif
            end
            default: sh_result = '0;
        endcase
    end

    always_comb begin
        prio_d      = prio_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        if (gnt_valid) begin
            prio_d      = !gnt_id;
            rsp_valid_d = 1'b1;
            rsp_data_d  = sh_result;
            rsp_id_d    = gnt_id;
            rsp_err_d   = sh_err;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a table of per-cycle request vectors with hand-computed results,
// plus reset, backpressure and mid-operation reset sequences. Honours SHIFT_ARB_ROTATE_EN for op 11.
module tb_shift_arbiter;
    localparam logic [1:0] SRL = 2'b00;
    localparam logic [1:0] SLL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

`ifdef SHIFT_ARB_ROTATE_EN
    localparam logic [63:0] ROT1    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ROT0    = 64'h0123_4567_89AB_CDEF;
    localparam logic        ROT_ERR = 1'b0;
`else
    localparam logic [63:0] ROT1    = 64'h0;
    localparam logic [63:0] ROT0    = 64'h0;
    localparam logic        ROT_ERR = 1'b1;
`endif

    typedef struct {
        logic        v0;
        logic [1:0]  op0;
        logic [5:0]  a0;
        logic [63:0] d0;
        logic        v1;
        logic [1:0]  op1;
        logic [5:0]  a1;
        logic [63:0] d1;
        logic        rr;
        logic        e_r0;
        logic        e_r1;
        logic        e_v;
        logic [63:0] e_data;
        logic        e_id;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    shift_arbiter_if #(.WIDTH(64)) bus ();

    shift_arbiter #(.WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic v0, input logic [1:0] op0, input logic [5:0] a0, input logic [63:0] d0,
        input logic v1, input logic [1:0] op1, input logic [5:0] a1, input logic [63:0] d1,
        input logic rr, input logic e_r0, input logic e_r1,
        input logic e_v, input logic [63:0] e_data, input logic e_id, input logic e_err);
        vec_t v;
        v.v0 = v0; v.op0 = op0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.op1 = op1; v.a1 = a1; v.d1 = d1;
        v.rr = rr; v.e_r0 = e_r0; v.e_r1 = e_r1;
        v.e_v = e_v; v.e_data = e_data; v.e_id = e_id; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called just after a rising edge: drive, check readies mid-cycle, then check the registered result.
    task automatic apply(input string tag, input vec_t v);
        bus.req0_valid = v.v0; bus.req0_op = v.op0; bus.req0_amt = v.a0; bus.req0_data = v.d0;
        bus.req1_valid = v.v1; bus.req1_op = v.op1; bus.req1_amt = v.a1; bus.req1_data = v.d1;
        bus.rsp_ready  = v.rr;
        #4;
        check({tag, " req0_ready"}, 64'(bus.req0_ready), 64'(v.e_r0));
        check({tag, " req1_ready"}, 64'(bus.req1_ready), 64'(v.e_r1));
        @(posedge clk);
        #1;
        check({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'(v.e_v));
        check({tag, " rsp_data"},  bus.rsp_data,        v.e_data);
        check({tag, " rsp_id"},    64'(bus.rsp_id),    64'(v.e_id));
        check({tag, " rsp_err"},   64'(bus.rsp_err),   64'(v.e_err));
    endtask

    vec_t tbl [9];

    initial begin
        // Priority is 1 entering the table: the reset sequence grants port 0 first.
        tbl[0] = mk(1, SRL, 63, 64'hFFFF_FFFF_FFFF_FFFF, 1, SLL, 63, 64'h1,
                    1, 0, 1, 1, 64'h8000_0000_0000_0000, 1, 0);
        tbl[1] = mk(1, SRL, 63, 64'hFFFF_FFFF_FFFF_FFFF, 1, ROR, 1, 64'h1,
                    1, 1, 0, 1, 64'h1, 0, 0);
        tbl[2] = mk(1, SRA, 0, 64'h1234, 1, ROR, 1, 64'h1,
                    1, 0, 1, 1, ROT1, 1, ROT_ERR);
        tbl[3] = mk(1, SRA, 0, 64'h1234, 1, SRL, 0, 64'hDEAD_BEEF,
                    1, 1, 0, 1, 64'h1234, 0, 0);
        tbl[4] = mk(0, SRL, 0, 64'h0, 1, SRL, 0, 64'hDEAD_BEEF,
                    1, 0, 1, 1, 64'hDEAD_BEEF, 1, 0);
        tbl[5] = mk(0, SRL, 0, 64'h0, 0, SRL, 0, 64'h0,
                    1, 0, 0, 0, 64'hDEAD_BEEF, 1, 0);
        tbl[6] = mk(0, SRL, 0, 64'h0, 1, SLL, 4, 64'hF0,
                    1, 0, 1, 1, 64'hF00, 1, 0);
        tbl[7] = mk(1, SRA, 4, 64'hF000_0000_0000_0000, 1, ROR, 0, 64'h0123_4567_89AB_CDEF,
                    1, 1, 0, 1, 64'hFF00_0000_0000_0000, 0, 0);
        tbl[8] = mk(0, SRL, 0, 64'h0, 1, ROR, 0, 64'h0123_4567_89AB_CDEF,
                    1, 0, 1, 1, ROT0, 1, ROT_ERR);

        // Reset with both ports valid: no readies, registers cleared.
        rst = 1'b1;
        apply("reset", mk(1, SRA, 1, 64'h8000_0000_0000_0001, 1, SLL, 63, 64'h1,
                          0, 0, 0, 0, 64'h0, 0, 0));
        rst = 1'b0;
        apply("first_grant", mk(1, SRA, 1, 64'h8000_0000_0000_0001, 1, SLL, 63, 64'h1,
                                1, 1, 0, 1, 64'hC000_0000_0000_0000, 0, 0));

        for (int i = 0; i < 9; i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Backpressure: result from vec8 must hold, readies stay low, priority (0) is kept.
        for (int i = 0; i < 3; i++)
            apply($sformatf("stall%0d", i),
                  mk(1, SRL, 8, 64'h100, 1, SLL, 2, 64'h3, 0, 0, 0, 1, ROT0, 1, ROT_ERR));
        apply("unstall_p0", mk(1, SRL, 8, 64'h100, 1, SLL, 2, 64'h3,
                               1, 1, 0, 1, 64'h1, 0, 0));
        apply("unstall_p1", mk(0, SRL, 0, 64'h0, 1, SLL, 2, 64'h3,
                               1, 0, 1, 1, 64'hC, 1, 0));
        apply("drain", mk(0, SRL, 0, 64'h0, 0, SRL, 0, 64'h0,
                          1, 0, 0, 0, 64'hC, 1, 0));

        // Reset right after an accept: pending result dropped, priority back to 0.
        apply("pre_rst_acc", mk(1, SLL, 4, 64'h10, 0, SRL, 0, 64'h0,
                                1, 1, 0, 1, 64'h100, 0, 0));
        rst = 1'b1;
        apply("mid_rst", mk(0, SRL, 0, 64'h0, 0, SRL, 0, 64'h0,
                            0, 0, 0, 0, 64'h0, 0, 0));
        rst = 1'b0;
        apply("post_rst", mk(1, SRL, 3, 64'h8, 1, SLL, 1, 64'h1,
                             1, 1, 0, 1, 64'h1, 0, 0));
        apply("post_rst_p1", mk(0, SRL, 0, 64'h0, 1, SLL, 1, 64'h1,
                                1, 0, 1, 1, 64'h2, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
